// File: rtl/cbc_stream_dec_if.sv
// rtl/cbc_stream_dec_if.sv - ciphertext-in / plaintext-out stream bundle for cbc_stream_dec
// in_last/frame_err exist only when CBC_STREAM_DEC_FRAME_CHECK_EN is defined.
interface cbc_stream_dec_if #(
  parameter int N = 1
);
  logic [8*N-1:0] key;
  logic [8*N-1:0] in_data;
  logic           in_valid;
  logic           in_ready;
  logic [8*N-1:0] out_data;
  logic           out_valid;
  logic           out_ready;
  logic           out_last;
`ifdef CBC_STREAM_DEC_FRAME_CHECK_EN
  logic           in_last;
  logic           frame_err;

  modport master (
    output key, in_data, in_valid, in_last, out_ready,
    input  in_ready, out_data, out_valid, out_last, frame_err
  );
  modport slave (
    input  key, in_data, in_valid, in_last, out_ready,
    output in_ready, out_data, out_valid, out_last, frame_err
  );
`else
  modport master (
    output key, in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, out_last
  );
  modport slave (
    input  key, in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, out_last
  );
`endif
endinterface

// File: rtl/cbc_stream_dec.sv
// rtl/cbc_stream_dec.sv - CBC-style XOR chain stream decryptor, M chunks of N bytes per message
// Optional framing check on in_last enabled by CBC_STREAM_DEC_FRAME_CHECK_EN.
module cbc_stream_dec #(
  parameter int N = 1,
  parameter int M = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  cbc_stream_dec_if.slave bus
);
  localparam int W  = 8 * N;
  localparam int CW = (M > 1) ? $clog2(M) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(M - 1);

  typedef enum logic {ST_FIRST, ST_CHAIN} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  chain_q, chain_d;
  logic [W-1:0]  data_q, data_d;
  logic          last_q, last_d;
  logic          valid_q, valid_d;

  logic          in_ready;
  logic          accept;
  logic          xfer;
  logic          at_end;
  logic          end_msg;
  logic [W-1:0]  seed;

  assign in_ready = !valid_q || bus.out_ready;
  assign accept   = bus.in_valid && in_ready;
  assign xfer     = valid_q && bus.out_ready;
  assign at_end   = (cnt_q == LAST_IDX);
  // Chunk 0 is whitened by the key; later chunks by the previous raw ciphertext.
  assign seed     = (state_q == ST_FIRST) ? bus.key : chain_q;

  assign bus.in_ready  = in_ready;
  assign bus.out_data  = data_q;
  assign bus.out_last  = last_q;
  assign bus.out_valid = valid_q;

`ifdef CBC_STREAM_DEC_FRAME_CHECK_EN
  logic ferr_q, ferr_d;

  // An early in_last closes the message; a missing one is flagged but the counter still closes it.
  assign end_msg       = at_end || bus.in_last;
  assign bus.frame_err = ferr_q;
`else
  assign end_msg = at_end;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    chain_d = chain_q;
    data_d  = data_q;
    last_d  = last_q;
    valid_d = valid_q;
`ifdef CBC_STREAM_DEC_FRAME_CHECK_EN
    ferr_d  = ferr_q;
`endif
    if (accept) begin
      chain_d = bus.in_data;
      data_d  = bus.in_data ^ seed;
      last_d  = end_msg;
      valid_d = 1'b1;
      if (end_msg) begin
        state_d = ST_FIRST;
        cnt_d   = '0;
      end else begin
        state_d = ST_CHAIN;
        cnt_d   = cnt_q + CW'(1);
      end
`ifdef CBC_STREAM_DEC_FRAME_CHECK_EN
      if (bus.in_last != at_end) begin
        ferr_d = 1'b1;
      end
`endif
    end else if (xfer) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_FIRST;
      cnt_q   <= '0;
      chain_q <= '0;
      data_q  <= '0;
      last_q  <= 1'b0;
      valid_q <= 1'b0;
`ifdef CBC_STREAM_DEC_FRAME_CHECK_EN
      ferr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      chain_q <= chain_d;
      data_q  <= data_d;
      last_q  <= last_d;
      valid_q <= valid_d;
`ifdef CBC_STREAM_DEC_FRAME_CHECK_EN
      ferr_q  <= ferr_d;
`endif
    end
  end
endmodule

// File: doc/cbc_stream_dec.md
CBC_STREAM_DEC -- requirements
Module: cbc_stream_dec

Interface
REQ-001 Parameter N, default 1: chunk width in bytes; chunk = 8*N bits; legal N >= 1.
REQ-002 Parameter M, default 2: chunks per message; legal M >= 1.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset; asynchronous, active-low.
REQ-005 key  input  8*N  chain seed; sampled only on acceptance of chunk 0 of a message.
REQ-006 in_valid  input  1  ciphertext chunk present on in_data.
REQ-007 in_ready  output  1  block can accept a chunk this cycle.
REQ-008 in_data  input  8*N  ciphertext chunk, message order chunk 0 first.
REQ-009 out_valid  output  1  plaintext chunk present on out_data.
REQ-010 out_ready  input  1  downstream accepts out_data this cycle.
REQ-011 out_data  output  8*N  plaintext chunk.
REQ-012 out_last  output  1  high with out_valid on the final chunk (index M-1) of a message.

Function
REQ-013 Input accept = in_valid && in_ready; output transfer = out_valid && out_ready.
REQ-014 Decryption: chunk 0 plaintext = in_data XOR key; chunk i>0 plaintext = in_data XOR ciphertext of chunk i-1 (raw input, not plaintext).
REQ-015 Chain register: on each accept, it is loaded with the accepted in_data.
REQ-016 FSM states FIRST (next accept is chunk 0) and CHAIN (next accept is chunk 1..M-1); reset state FIRST.
REQ-017 FIRST, accept: go to CHAIN if M>1, stay in FIRST if M==1.
REQ-018 CHAIN, accept: increment chunk counter; on accept with counter == M-1, go to FIRST with counter 0.
REQ-019 Chunk counter width = max(1,$clog2(M)); it never exceeds M-1.
REQ-020 Output stage: one register holding out_data/out_last/out_valid; latency is exactly one cycle from accept to out_valid.
REQ-021 in_ready = !out_valid || out_ready (combinational); full throughput of one chunk per cycle under continuous out_ready.
REQ-022 Simultaneous output transfer and input accept in the same cycle: output register reloads with the new chunk; out_valid stays high.
REQ-023 Output transfer without accept: out_valid clears next cycle.
REQ-024 While out_valid && !out_ready: out_data, out_last, out_valid are held stable; no accept occurs.
REQ-025 Changes on key while in CHAIN have no effect on the current message.
REQ-026 With M==1 every output chunk has out_last high and equals in_data XOR key.

Reset
REQ-027 rst_n low asynchronously forces: out_valid=0, out_last=0, out_data=0, chain register=0, counter=0, state FIRST.
REQ-028 Reset mid-message discards the partial message and any held output chunk; the first accept after reset is chunk 0.
REQ-029 in_ready is 1 during and immediately after reset (follows from out_valid=0).

Configuration
REQ-030 Macro CBC_STREAM_DEC_FRAME_CHECK_EN defined: adds input in_last (1 bit, framing marker with in_data) and output frame_err (1 bit, sticky, reset 0).
REQ-031 With the macro: accept with in_last != (counter==M-1) sets frame_err; if in_last is high early, the chunk is decrypted, emitted with out_last=1, and the FSM returns to FIRST with counter 0.
REQ-032 With the macro: a missing in_last on chunk M-1 sets frame_err; framing still follows the counter.
REQ-033 Without the macro: ports in_last and frame_err do not exist; framing is by counter only.

Verification
REQ-034 N=1,M=2, key=0x59, out_ready=1, send 0x2A then 0xB0 back-to-back -> out_data 0x73 (out_last=0) then 0x9A (out_last=1), one cycle after each accept.
REQ-035 N=2,M=4, key=0x0AFB, send 0xF5AF,0xE48C,0x46D5,0xCD18 -> 0xFF54,0x1123,0xA259,0x8BCD, out_last only on the fourth; repeat with key=0x1234 and 0xDFDB,0x5670,0x1317,0x1234 -> 0xCDEF,0x89AB,0x4567,0x0123.
REQ-036 N=1,M=2, hold out_ready=0 for 3 cycles after first output -> in_ready=0, out_data held at 0x73, second chunk not accepted until out_ready=1.
REQ-037 N=1,M=2, key=0xE7, accept 0xE7, pulse rst_n low, then send 0xE7,0xE7 -> outputs 0x00,0x00 (no chain from the pre-reset chunk).
REQ-038 With CBC_STREAM_DEC_FRAME_CHECK_EN, N=2,M=4: in_last=1 on the second chunk -> frame_err=1, that output has out_last=1, next chunk is decrypted against key.
